ser_to_par_8bit: RTL and testbench

//  Serial-to-parallel front end for the 8-bit load register stage.

---
 rtl/ser_to_par_8bit.sv | 192 +++++++++++++++++++
 tb/tb_ser_to_par_8bit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ser_to_par_8bit.sv
// ser_to_par_8bit: assembles a framed serial bit stream into a WIDTH-bit
// word and presents it with a one-cycle load strobe for a downstream
// register (Dout -> Din, ld -> ld).
// Optional feature macro: SER_PARITY_CHK_EN -- adds an even-parity bit
// after the data bits and reports mismatches on par_err.
module ser_to_par_8bit #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] Dout,
    output logic             ld,
    output logic             busy,
    output logic [3:0]       bit_cnt,
    output logic             par_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic             ld_reg, ld_next;
    logic             last_bit;

    assign last_bit = (bit_cnt_reg == LAST_CNT);

    // Shift register with the new bit inserted at the end selected by MSB_FIRST
    // (first bit received migrates to Dout[WIDTH-1] or Dout[0]).
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign shifted[gi] = sin;
                end else begin : g_mv
                    assign shifted[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_in
                    assign shifted[gi] = sin;
                end else begin : g_mv
                    assign shifted[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start always wins over sin_valid.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (start) begin
                    state_next = ST_SHIFT;
                end else if (sin_valid && last_bit) begin
`ifdef SER_PARITY_CHK_EN
                    state_next = ST_PAR;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef SER_PARITY_CHK_EN
            ST_PAR: begin
                if (start) begin
                    state_next = ST_SHIFT;
                end else if (sin_valid) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic decoded from the state.
    always_comb begin
        busy = (state_reg != ST_IDLE);
    end

`ifdef SER_PARITY_CHK_EN
    logic par_err_reg, par_err_next;
`endif

    // Datapath next values: shifting, bit counting, word delivery and strobe.
    always_comb begin
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        dout_next    = dout_reg;
        ld_next      = 1'b0;
`ifdef SER_PARITY_CHK_EN
        par_err_next = par_err_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    shift_next   = '0;
                    bit_cnt_next = '0;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    shift_next   = '0;
                    bit_cnt_next = '0;
                end else if (sin_valid) begin
                    shift_next = shifted;
                    if (last_bit) begin
                        bit_cnt_next = '0;
`ifndef SER_PARITY_CHK_EN
                        dout_next = shifted;
                        ld_next   = 1'b1;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
`ifdef SER_PARITY_CHK_EN
            ST_PAR: begin
                if (start) begin
                    shift_next   = '0;
                    bit_cnt_next = '0;
                end else if (sin_valid) begin
                    // Word is delivered even on a parity failure.
                    dout_next    = shift_reg;
                    ld_next      = 1'b1;
                    par_err_next = (^shift_reg) ^ sin;
                end
            end
`endif
            default: begin
                shift_next   = '0;
                bit_cnt_next = '0;
            end
        endcase
    end

    // Datapath registers; reset discards any partial word without a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            dout_reg    <= '0;
            ld_reg      <= 1'b0;
`ifdef SER_PARITY_CHK_EN
            par_err_reg <= 1'b0;
`endif
        end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            dout_reg    <= dout_next;
            ld_reg      <= ld_next;
`ifdef SER_PARITY_CHK_EN
            par_err_reg <= par_err_next;
`endif
        end
    end

    assign Dout    = dout_reg;
    assign ld      = ld_reg;
    assign bit_cnt = bit_cnt_reg;
`ifdef SER_PARITY_CHK_EN
    assign par_err = par_err_reg;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ser_to_par_8bit.sv
// tb_ser_to_par_8bit: directed-vector bench for ser_to_par_8bit (WIDTH=8,
// MSB_FIRST=1). Covers SER_PARITY_CHK_EN when the macro is defined.
module tb_ser_to_par_8bit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sin;
    logic       sin_valid;
    logic [7:0] Dout;
    logic       ld;
    logic       busy;
    logic [3:0] bit_cnt;
    logic       par_err;

    int n_cmp = 0;
    int n_bad = 0;
    int ld_cnt = 0;

    ser_to_par_8bit #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sin      (sin),
        .sin_valid(sin_valid),
        .Dout     (Dout),
        .ld       (ld),
        .busy     (busy),
        .bit_cnt  (bit_cnt),
        .par_err  (par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_cmp++;
        if (obs !== exp_val) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it and ld pulses counted.
    task automatic step();
        @(posedge clk);
        #1;
        if (ld === 1'b1) ld_cnt++;
    endtask

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        step();
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Send a data word MSB first with gap idle cycles after each bit,
    // followed by the parity bit when the parity build is in use.
    task automatic send_word(input logic [7:0] w, input int gap, input logic par_bit);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            repeat (gap) step();
        end
`ifdef SER_PARITY_CHK_EN
        send_bit(par_bit);
`else
        if (par_bit) begin end
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;

        // Reset held 3 cycles while start/sin_valid toggle.
        for (int i = 0; i < 3; i++) begin
            start     = (i % 2 == 0);
            sin_valid = (i % 2 != 0);
            sin       = 1'b1;
            step();
        end
        check("rst_dout", 32'(Dout), 32'h0);
        check("rst_ld", 32'(ld), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_bitcnt", 32'(bit_cnt), 32'h0);
        check("rst_parerr", 32'(par_err), 32'h0);
        reset = 1'b0; start = 1'b0; sin_valid = 1'b0; sin = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'h0);

        // Reset after 5 bits: no strobe, Dout keeps 0.
        ld_cnt = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("mid_bitcnt", 32'(bit_cnt), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_bitcnt", 32'(bit_cnt), 32'h0);
        repeat (3) send_bit(1'b1);
        step();
        check("midrst_ldcnt", 32'(ld_cnt), 32'd0);
        check("midrst_dout", 32'(Dout), 32'h0);

        // Basic frame 0xA5.
        ld_cnt = 0;
        pulse_start();
        check("basic_busy", 32'(busy), 32'h1);
        check("basic_cnt0", 32'(bit_cnt), 32'h0);
        send_word(8'hA5, 0, 1'b0);
        check("basic_ld", 32'(ld), 32'h1);
        check("basic_dout", 32'(Dout), 32'hA5);
        check("basic_busy_fall", 32'(busy), 32'h0);
        check("basic_cnt_end", 32'(bit_cnt), 32'h0);
        step();
        check("basic_ld_off", 32'(ld), 32'h0);
        check("basic_dout_hold", 32'(Dout), 32'hA5);
        check("basic_ldcnt", 32'(ld_cnt), 32'd1);

        // Gapped frame; sin_valid stays low 2 cycles between bits.
        ld_cnt = 0;
        pulse_start();
        send_word(8'h96, 2, 1'b0);
        step();
        check("gap_dout", 32'(Dout), 32'h96);
        check("gap_ldcnt", 32'(ld_cnt), 32'd1);

        // Abort: 4 bits, restart, then 0x3C.
        ld_cnt = 0;
        pulse_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        start = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        step();
        start = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        check("abort_cnt", 32'(bit_cnt), 32'h0);
        check("abort_dout_keep", 32'(Dout), 32'h96);
        send_word(8'h3C, 0, 1'b0);
        step();
        check("abort_dout", 32'(Dout), 32'h3C);
        check("abort_ldcnt", 32'(ld_cnt), 32'd1);

        // start together with sin_valid in IDLE: that bit is not sampled.
        ld_cnt = 0;
        start = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        step();
        start = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        check("ss_cnt", 32'(bit_cnt), 32'h0);
        send_word(8'h12, 0, 1'b0);
        check("ss_dout", 32'(Dout), 32'h12);

        // Back-to-back: start during the ld cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'h1);
        check("b2b_ld_off", 32'(ld), 32'h0);
        send_word(8'h5A, 0, 1'b0);
        check("b2b_dout", 32'(Dout), 32'h5A);
        step();
        check("b2b_ldcnt", 32'(ld_cnt), 32'd2);

`ifdef SER_PARITY_CHK_EN
        // Even parity: 0xA5 has four ones.
        pulse_start();
        send_word(8'hA5, 0, 1'b0);
        check("par_ok_ld", 32'(ld), 32'h1);
        check("par_ok_err", 32'(par_err), 32'h0);
        pulse_start();
        send_word(8'hA5, 0, 1'b1);
        check("par_bad_ld", 32'(ld), 32'h1);
        check("par_bad_dout", 32'(Dout), 32'hA5);
        check("par_bad_err", 32'(par_err), 32'h1);
        step();
        check("par_err_hold", 32'(par_err), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
